// File: rtl/cdb_pkg.sv
// Shared types and defaults for the common data bus (CDB) arbiter.
// Latency: none, this file holds declarations only.
// Backpressure: none, this file holds declarations only.
package cdb_pkg;

  localparam int TAG_W_DEF  = 3;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    SRC_ADD = 2'd0,
    SRC_MUL = 2'd1,
    SRC_BR  = 2'd2
  } cdb_src_e;

  // Bus-level layout of one broadcast at the default widths.
  typedef struct packed {
    cdb_src_e                src;
    logic [TAG_W_DEF-1:0]    tag;
    logic [DATA_W_DEF-1:0]   value;
    logic                    exception;
  } cdb_pkt_t;

endpackage

// File: rtl/rr_pick3.sv
// Three-way round-robin picker: one-hot grant starting the search after `last`.
// Latency: purely combinational.
// Backpressure: none; an empty request mask yields an all-zero grant.
module rr_pick3
  import cdb_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] last,
  output logic [2:0] gnt
);

  // Search order is last+1, last+2, last+3 (mod 3).
  always_comb begin
    gnt = 3'b000;
    case (last)
      SRC_ADD: begin
        if      (req[SRC_MUL]) gnt = 3'b010;
        else if (req[SRC_BR])  gnt = 3'b100;
        else if (req[SRC_ADD]) gnt = 3'b001;
      end
      SRC_MUL: begin
        if      (req[SRC_BR])  gnt = 3'b100;
        else if (req[SRC_ADD]) gnt = 3'b001;
        else if (req[SRC_MUL]) gnt = 3'b010;
      end
      default: begin
        if      (req[SRC_ADD]) gnt = 3'b001;
        else if (req[SRC_MUL]) gnt = 3'b010;
        else if (req[SRC_BR])  gnt = 3'b100;
      end
    endcase
  end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB arbiter: picks one of ADD/MUL/BR per cycle and broadcasts it from a register.
// Latency: 1 cycle from transfer (valid & ready at posedge) to cdb_valid.
// Backpressure: ready is combinational, at most one high, none during flush/reset.
// Optional CDB_BRANCH_PRIORITY_EN: branch wins unless ADD or MUL is starved.
module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int TAG_W        = TAG_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              add_valid,
  input  logic [TAG_W-1:0]  add_tag,
  input  logic [DATA_W-1:0] add_value,
  input  logic              mul_valid,
  input  logic [TAG_W-1:0]  mul_tag,
  input  logic [DATA_W-1:0] mul_value,
  input  logic              branch_valid,
  input  logic [TAG_W-1:0]  branch_tag,
  input  logic [DATA_W-1:0] branch_value,
  input  logic              branch_exception,
  output logic              add_ready,
  output logic              mul_ready,
  output logic              branch_ready,
  output logic              cdb_valid,
  output logic [1:0]        cdb_src,
  output logic [TAG_W-1:0]  cdb_tag,
  output logic [DATA_W-1:0] cdb_value,
  output logic              cdb_exception
);

  // STARVE_LIMIT must be at least 1 so the counters have a width.
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  cdb_src_e          last;
  logic [2:0]        req;
  logic [2:0]        rr_gnt;
  logic [2:0]        gnt;
  logic [2:0]        rdy;
  logic [2:0]        xfer;
  logic [CNT_W-1:0]  wait_cnt [3];

  cdb_src_e          win_src;
  logic [TAG_W-1:0]  win_tag;
  logic [DATA_W-1:0] win_value;

  assign req = {branch_valid, mul_valid, add_valid};

  rr_pick3 u_rr (
    .req  (req),
    .last (last),
    .gnt  (rr_gnt)
  );

`ifdef CDB_BRANCH_PRIORITY_EN
  logic [2:0] starved;
  logic [2:0] starve_gnt;

  assign starved = {1'b0,
                    mul_valid && (wait_cnt[SRC_MUL] == CNT_MAX),
                    add_valid && (wait_cnt[SRC_ADD] == CNT_MAX)};

  // Starved sources share the normal rr order among themselves.
  rr_pick3 u_rr_starve (
    .req  (starved),
    .last (last),
    .gnt  (starve_gnt)
  );

  // Starvation override first, then branch priority, then plain round-robin.
  always_comb begin
    gnt = rr_gnt;
    if (|starved)          gnt = starve_gnt;
    else if (branch_valid) gnt = 3'b100;
  end
`else
  assign gnt = rr_gnt;

  // Pure round-robin: nobody is passed over more than twice in a row.
  assert property (@(posedge clk) disable iff (!rst_n)
    int'(wait_cnt[0]) <= 2 && int'(wait_cnt[1]) <= 2 && int'(wait_cnt[2]) <= 2);
`endif

  // Reset is folded in so no grant is visible while the arbiter is held in reset.
  assign rdy  = (rst_n && !flush) ? gnt : 3'b000;
  assign xfer = req & rdy;
  assign {branch_ready, mul_ready, add_ready} = rdy;

  // Select the winning source and its payload.
  always_comb begin
    win_src   = SRC_BR;
    win_tag   = branch_tag;
    win_value = branch_value;
    if (xfer[SRC_ADD]) begin
      win_src   = SRC_ADD;
      win_tag   = add_tag;
      win_value = add_value;
    end else if (xfer[SRC_MUL]) begin
      win_src   = SRC_MUL;
      win_tag   = mul_tag;
      win_value = mul_value;
    end
  end

  // Per-source wait counters, saturating, cleared on grant, idle or flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) wait_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (!req[i] || xfer[i] || flush) wait_cnt[i] <= '0;
        else if (wait_cnt[i] != CNT_MAX) wait_cnt[i] <= wait_cnt[i] + 1'b1;
      end
    end
  end

  // Round-robin pointer follows the last granted source.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     last <= SRC_BR;
    else if (|xfer) last <= win_src;
  end

  // Broadcast register: one-cycle valid, payload holds while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cdb_valid     <= 1'b0;
      cdb_src       <= 2'd0;
      cdb_tag       <= '0;
      cdb_value     <= '0;
      cdb_exception <= 1'b0;
    end else begin
      cdb_valid <= (|xfer) && !flush;
      if (|xfer) begin
        cdb_src       <= win_src;
        cdb_tag       <= win_tag;
        cdb_value     <= win_value;
        cdb_exception <= xfer[SRC_BR] && branch_exception;
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: spec-level model compared every negedge,
// plus directed vectors with literal expectations.
module tb_cdb_arbiter;

  localparam int TAG_W  = 3;
  localparam int DATA_W = 32;
  localparam int LIMIT  = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              flush = 1'b0;
  logic              add_valid = 1'b0, mul_valid = 1'b0, branch_valid = 1'b0;
  logic [TAG_W-1:0]  add_tag = '0, mul_tag = '0, branch_tag = '0;
  logic [DATA_W-1:0] add_value = '0, mul_value = '0, branch_value = '0;
  logic              branch_exception = 1'b0;
  logic              add_ready, mul_ready, branch_ready;
  logic              cdb_valid;
  logic [1:0]        cdb_src;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_value;
  logic              cdb_exception;

  int checks = 0;
  int failures = 0;

  cdb_arbiter #(.TAG_W(TAG_W), .DATA_W(DATA_W), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .add_valid(add_valid), .add_tag(add_tag), .add_value(add_value),
    .mul_valid(mul_valid), .mul_tag(mul_tag), .mul_value(mul_value),
    .branch_valid(branch_valid), .branch_tag(branch_tag), .branch_value(branch_value),
    .branch_exception(branch_exception),
    .add_ready(add_ready), .mul_ready(mul_ready), .branch_ready(branch_ready),
    .cdb_valid(cdb_valid), .cdb_src(cdb_src), .cdb_tag(cdb_tag),
    .cdb_value(cdb_value), .cdb_exception(cdb_exception)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_last = 2;
  int          m_wait [3] = '{0, 0, 0};
  bit          m_cv = 0;
  int          m_src = 0;
  logic [31:0] m_tag = 0, m_val = 0;
  bit          m_exc = 0;

  int          n_last = 2;
  int          n_wait [3] = '{0, 0, 0};
  bit          n_cv = 0;
  int          n_src = 0;
  logic [31:0] n_tag = 0, n_val = 0;
  bit          n_exc = 0;

  // First requester found when walking the ring after the last winner.
  function automatic int rr_from(bit [2:0] m);
    int s;
    for (int k = 1; k <= 3; k++) begin
      s = (m_last + k) % 3;
      if (m[s]) return s;
    end
    return -1;
  endfunction

  function automatic int model_pick(bit [2:0] v, bit fl);
    bit [2:0] st;
    if (fl) return -1;
    st = 3'b000;
`ifdef CDB_BRANCH_PRIORITY_EN
    st[0] = v[0] && (m_wait[0] == LIMIT);
    st[1] = v[1] && (m_wait[1] == LIMIT);
    if (st != 3'b000) return rr_from(st);
    if (v[2]) return 2;
`endif
    return rr_from(v | st);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_last = 2; m_wait = '{0, 0, 0};
      m_cv = 0; m_src = 0; m_tag = 0; m_val = 0; m_exc = 0;
    end else begin
      m_last = n_last; m_wait = n_wait;
      m_cv = n_cv; m_src = n_src; m_tag = n_tag; m_val = n_val; m_exc = n_exc;
    end
  end

  // Single compare process: outputs vs model, then model next state.
  always @(negedge clk) begin
    bit [2:0] v;
    int g;
    v = {branch_valid, mul_valid, add_valid};
    g = rst_n ? model_pick(v, flush) : -1;
    chk("m_add_ready", add_ready, g == 0);
    chk("m_mul_ready", mul_ready, g == 1);
    chk("m_br_ready",  branch_ready, g == 2);
    chk("m_cdb_valid", cdb_valid, m_cv);
    chk("m_cdb_src",   cdb_src, m_src);
    chk("m_cdb_tag",   cdb_tag, m_tag);
    chk("m_cdb_value", cdb_value, m_val);
    chk("m_cdb_exc",   cdb_exception, m_exc);
    n_last = m_last; n_wait = m_wait;
    n_cv = 0; n_src = m_src; n_tag = m_tag; n_val = m_val; n_exc = m_exc;
    if (g >= 0) begin
      n_cv = 1; n_src = g; n_last = g;
      n_tag = (g == 0) ? add_tag : (g == 1) ? mul_tag : branch_tag;
      n_val = (g == 0) ? add_value : (g == 1) ? mul_value : branch_value;
      n_exc = (g == 2) && branch_exception;
    end
    for (int i = 0; i < 3; i++)
      n_wait[i] = (flush || !v[i] || g == i) ? 0 : ((m_wait[i] < LIMIT) ? m_wait[i] + 1 : LIMIT);
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    add_tag = 3'd1; add_value = 32'h11;
    mul_tag = 3'd2; mul_value = 32'h22;
    branch_tag = 3'd6; branch_value = 32'h66;
    add_valid = 1; mul_valid = 1; branch_valid = 1;

    // Reset with everything requesting
    step(); step();
    chk("rst_add_ready", add_ready, 0);
    chk("rst_mul_ready", mul_ready, 0);
    chk("rst_br_ready", branch_ready, 0);
    chk("rst_cdb_valid", cdb_valid, 0);
    chk("rst_cdb_tag", cdb_tag, 0);
    rst_n = 1;
    #1 chk("release_add_first", add_ready, 1);

    // All three valid back-to-back
    for (int k = 0; k < 6; k++) begin
      step();
      chk("rr_cdb_valid", cdb_valid, 1);
`ifndef CDB_BRANCH_PRIORITY_EN
      chk("rr_cdb_src", cdb_src, k % 3);
`endif
    end
    add_valid = 0; mul_valid = 0; branch_valid = 0;
    step();
    chk("idle_cdb_valid", cdb_valid, 0);

    // Single ADD transfer; stray branch_exception must not leak
    add_valid = 1; add_tag = 3'd5; add_value = 32'h2A; branch_exception = 1;
    #1 chk("single_add_ready", add_ready, 1);
    step();
    add_valid = 0; branch_exception = 0;
    #1;
    chk("single_cdb_valid", cdb_valid, 1);
    chk("single_cdb_src", cdb_src, 0);
    chk("single_cdb_tag", cdb_tag, 5);
    chk("single_cdb_value", cdb_value, 32'h2A);
    chk("single_cdb_exc", cdb_exception, 0);
    step();
    chk("hold_cdb_valid", cdb_valid, 0);
    chk("hold_cdb_tag", cdb_tag, 5);
    chk("hold_cdb_value", cdb_value, 32'h2A);

    // Flush blocks the grant in its cycle
    mul_valid = 1; mul_tag = 3'd4; mul_value = 32'h77; flush = 1;
    #1 chk("flush_mul_ready", mul_ready, 0);
    step();
    flush = 0;
    #1;
    chk("flush_cdb_valid", cdb_valid, 0);
    chk("after_flush_mul_ready", mul_ready, 1);
    step();
    mul_valid = 0;
    #1;
    chk("flush_late_cdb_valid", cdb_valid, 1);
    chk("flush_late_cdb_src", cdb_src, 1);
    chk("flush_late_cdb_tag", cdb_tag, 4);
    step();

    // Branch and ADD contending continuously
    add_valid = 1; add_tag = 3'd7; add_value = 32'hA7;
    branch_valid = 1; branch_tag = 3'd6; branch_value = 32'h66;
    for (int k = 0; k < 6; k++) begin
      #1;
`ifdef CDB_BRANCH_PRIORITY_EN
      chk("starve_br_ready", branch_ready, k != 4);
      chk("starve_add_ready", add_ready, k == 4);
`endif
      step();
    end
    add_valid = 0; branch_valid = 0;
    step();

    // Mispredict broadcast, then async reset mid-broadcast
    branch_valid = 1; branch_exception = 1; branch_tag = 3'd3; branch_value = 32'h100;
    #1 chk("mis_br_ready", branch_ready, 1);
    step();
    branch_valid = 0; branch_exception = 0; add_valid = 1;
    #1;
    chk("mis_cdb_valid", cdb_valid, 1);
    chk("mis_cdb_exc", cdb_exception, 1);
    chk("mis_cdb_value", cdb_value, 32'h100);
    chk("mis_cdb_src", cdb_src, 2);
    chk("mis_cdb_tag", cdb_tag, 3);
    rst_n = 0;
    #1;
    chk("arst_cdb_valid", cdb_valid, 0);
    chk("arst_cdb_exc", cdb_exception, 0);
    chk("arst_add_ready", add_ready, 0);
    step(); step();
    rst_n = 1;
    #1 chk("rerelease_add_ready", add_ready, 1);
    step();
    add_valid = 0;
    #1 chk("rerelease_cdb_src", cdb_src, 0);
    step(); step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
